// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared types and constants for the 16-bit to 8-bit memory word bridge.
//   bridge_state_t : bridge FSM state encoding
//   HI_BYTE_OFS    : byte-address LSB of the high (big-endian first) byte
//   LO_BYTE_OFS    : byte-address LSB of the low byte
//   WORD_W, BYTE_W : CPU word width and memory byte width
package mem_bridge_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned BYTE_W = 8;

    // Big-endian: the high byte lives at the even byte address.
    localparam logic HI_BYTE_OFS = 1'b0;
    localparam logic LO_BYTE_OFS = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StRdHi,
        StRdLo,
        StRdCap,
        StWrHi,
        StWrLo
    } bridge_state_t;

endpackage

// File: rtl/mem_word_bridge_if.sv
// mem_word_bridge_if: CPU word-request channel plus 8-bit on-chip memory port.
//   cpu_req/cpu_we/cpu_addr/cpu_wdata : word request from the core
//   cpu_be                            : byte enables (only with MEM_BRIDGE_BYTE_ENABLE_EN)
//   cpu_ready/cpu_rvalid/cpu_rdata    : acceptance and read-return to the core
//   mem_address..mem_writedata        : byte strobes towards memory_system
//   mem_readdata                      : byte returned by memory, one cycle after a read strobe
// Modports: slave = bridge view, master = environment (core + memory) view.
// Optional feature macro: MEM_BRIDGE_BYTE_ENABLE_EN.
interface mem_word_bridge_if
    import mem_bridge_pkg::*;
#(
    parameter int unsigned WADDR_W = 9
);
    logic                cpu_req;
    logic                cpu_we;
    logic [WADDR_W-1:0]  cpu_addr;
    logic [WORD_W-1:0]   cpu_wdata;
`ifdef MEM_BRIDGE_BYTE_ENABLE_EN
    logic [1:0]          cpu_be;
`endif
    logic                cpu_ready;
    logic                cpu_rvalid;
    logic [WORD_W-1:0]   cpu_rdata;

    logic [WADDR_W:0]    mem_address;
    logic                mem_clken;
    logic                mem_chipselect;
    logic                mem_write;
    logic [BYTE_W-1:0]   mem_writedata;
    logic [BYTE_W-1:0]   mem_readdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
`ifdef MEM_BRIDGE_BYTE_ENABLE_EN
        input  cpu_be,
`endif
        input  mem_readdata,
        output cpu_ready, cpu_rvalid, cpu_rdata,
        output mem_address, mem_clken, mem_chipselect, mem_write, mem_writedata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
`ifdef MEM_BRIDGE_BYTE_ENABLE_EN
        output cpu_be,
`endif
        output mem_readdata,
        input  cpu_ready, cpu_rvalid, cpu_rdata,
        input  mem_address, mem_clken, mem_chipselect, mem_write, mem_writedata
    );

endinterface

// File: rtl/mem_word_bridge.sv
// mem_word_bridge: splits 16-bit word reads/writes from the core into two big-endian
// 8-bit accesses on a 1-cycle-latency on-chip memory port and reassembles read words.
//   clk   : single clock, shared with the memory
//   reset : synchronous, active-high
//   bus   : mem_word_bridge_if.slave (CPU request channel + memory byte port)
// Parameters: WADDR_W word-address width (byte address is WADDR_W+1 bits),
//             RD_LAT memory read latency (only 1 is supported).
// Optional feature macro: MEM_BRIDGE_BYTE_ENABLE_EN adds per-byte write enables.
module mem_word_bridge
    import mem_bridge_pkg::*;
#(
    parameter int unsigned WADDR_W = 9,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic             clk,
    input  logic             reset,
    mem_word_bridge_if.slave bus
);

    if (RD_LAT != 1) begin : g_rd_lat_check
        $error("mem_word_bridge: only RD_LAT == 1 is supported");
    end

    bridge_state_t       state_q, state_d;
    logic [WADDR_W-1:0]  addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [BYTE_W-1:0]   rdata_hi_q, rdata_hi_d;
    logic [WORD_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
`ifdef MEM_BRIDGE_BYTE_ENABLE_EN
    logic [1:0]          be_q, be_d;
`endif

    logic [WADDR_W:0]    mem_addr;
    logic                mem_cs;
    logic                mem_we;
    logic [BYTE_W-1:0]   mem_wd;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_hi_d = rdata_hi_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
`ifdef MEM_BRIDGE_BYTE_ENABLE_EN
        be_d       = be_q;
`endif
        mem_addr   = '0;
        mem_cs     = 1'b0;
        mem_we     = 1'b0;
        mem_wd     = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.cpu_req) begin
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
`ifdef MEM_BRIDGE_BYTE_ENABLE_EN
                    be_d    = bus.cpu_be;
                    if (!bus.cpu_we) begin
                        state_d = StRdHi;
                    end else if (bus.cpu_be[1]) begin
                        state_d = StWrHi;
                    end else if (bus.cpu_be[0]) begin
                        state_d = StWrLo;
                    end else begin
                        // No enabled byte: accept and complete without touching memory.
                        state_d = StIdle;
                    end
`else
                    state_d = bus.cpu_we ? StWrHi : StRdHi;
`endif
                end
            end
            StRdHi: begin
                mem_addr = {addr_q, HI_BYTE_OFS};
                mem_cs   = 1'b1;
                state_d  = StRdLo;
            end
            StRdLo: begin
                mem_addr   = {addr_q, LO_BYTE_OFS};
                mem_cs     = 1'b1;
                rdata_hi_d = bus.mem_readdata;
                state_d    = StRdCap;
            end
            StRdCap: begin
                // Publish the whole word at once so cpu_rdata holds until this read completes.
                rdata_d  = {rdata_hi_q, bus.mem_readdata};
                rvalid_d = 1'b1;
                state_d  = StIdle;
            end
            StWrHi: begin
                mem_addr = {addr_q, HI_BYTE_OFS};
                mem_cs   = 1'b1;
                mem_we   = 1'b1;
                mem_wd   = wdata_q[WORD_W-1:BYTE_W];
`ifdef MEM_BRIDGE_BYTE_ENABLE_EN
                state_d  = be_q[0] ? StWrLo : StIdle;
`else
                state_d  = StWrLo;
`endif
            end
            StWrLo: begin
                mem_addr = {addr_q, LO_BYTE_OFS};
                mem_cs   = 1'b1;
                mem_we   = 1'b1;
                mem_wd   = wdata_q[BYTE_W-1:0];
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_hi_q <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
`ifdef MEM_BRIDGE_BYTE_ENABLE_EN
            be_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_hi_q <= rdata_hi_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
`ifdef MEM_BRIDGE_BYTE_ENABLE_EN
            be_q       <= be_d;
`endif
        end
    end

    // Memory strobes are squashed while reset is high so an interrupted access
    // cannot issue another byte in the reset cycle.
    assign bus.mem_clken      = ~reset;
    assign bus.mem_chipselect = mem_cs & ~reset;
    assign bus.mem_write      = mem_we & ~reset;
    assign bus.mem_address    = reset ? '0 : mem_addr;
    assign bus.mem_writedata  = reset ? '0 : mem_wd;

    assign bus.cpu_ready  = (state_q == StIdle);
    assign bus.cpu_rvalid = rvalid_q;
    assign bus.cpu_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_word_bridge.sv
// tb_mem_word_bridge: directed self-checking bench for mem_word_bridge with a
// 1024-byte, 1-cycle-read-latency memory model. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_mem_word_bridge;

    localparam int unsigned WADDR_W = 9;

    logic clk = 1'b0;
    logic reset;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem    [0:1023];
    logic [7:0] shadow [0:1023];

    mem_word_bridge_if #(.WADDR_W(WADDR_W)) bus ();

    mem_word_bridge #(
        .WADDR_W(WADDR_W),
        .RD_LAT (1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Memory model: writes land at the strobe edge, read data appears one cycle later.
    always @(posedge clk) begin
        if (bus.mem_chipselect && bus.mem_clken) begin
            if (bus.mem_write) mem[bus.mem_address] <= bus.mem_writedata;
            else bus.mem_readdata <= mem[bus.mem_address];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic mem_compare(input string tag);
        int diffs = 0;
        for (int i = 0; i < 1024; i++) begin
            if (mem[i] !== shadow[i]) diffs++;
        end
        chk(tag, diffs, 0);
    endtask

    // Starts at a falling edge with the bridge idle; returns at the falling edge of the
    // rvalid cycle (cycle 4 relative to acceptance).
    task automatic do_read(input logic [8:0] a, input logic [15:0] exp, input string tag);
        chk({tag, ".ready"}, bus.cpu_ready, 1);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = a;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        chk({tag, ".c1_addr"}, bus.mem_address, {a, 1'b0});
        chk({tag, ".c1_cs"}, bus.mem_chipselect, 1);
        chk({tag, ".c1_we"}, bus.mem_write, 0);
        chk({tag, ".c1_rvalid"}, bus.cpu_rvalid, 0);
        @(negedge clk);
        chk({tag, ".c2_addr"}, bus.mem_address, {a, 1'b1});
        chk({tag, ".c2_cs"}, bus.mem_chipselect, 1);
        @(negedge clk);
        chk({tag, ".c3_cs"}, bus.mem_chipselect, 0);
        chk({tag, ".c3_rvalid"}, bus.cpu_rvalid, 0);
        @(negedge clk);
        chk({tag, ".c4_rvalid"}, bus.cpu_rvalid, 1);
        chk({tag, ".c4_rdata"}, bus.cpu_rdata, exp);
        chk({tag, ".c4_ready"}, bus.cpu_ready, 1);
    endtask

    // Full-word write; returns at the falling edge of cycle 3 (ready again).
    task automatic do_write(input logic [8:0] a, input logic [15:0] d, input string tag);
        chk({tag, ".ready"}, bus.cpu_ready, 1);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
`ifdef MEM_BRIDGE_BYTE_ENABLE_EN
        bus.cpu_be    = 2'b11;
`endif
        @(negedge clk);
        bus.cpu_req = 1'b0;
        chk({tag, ".c1_addr"}, bus.mem_address, {a, 1'b0});
        chk({tag, ".c1_we"}, bus.mem_write, 1);
        chk({tag, ".c1_cs"}, bus.mem_chipselect, 1);
        chk({tag, ".c1_wd"}, bus.mem_writedata, d[15:8]);
        chk({tag, ".c1_ready"}, bus.cpu_ready, 0);
        @(negedge clk);
        chk({tag, ".c2_addr"}, bus.mem_address, {a, 1'b1});
        chk({tag, ".c2_we"}, bus.mem_write, 1);
        chk({tag, ".c2_wd"}, bus.mem_writedata, d[7:0]);
        @(negedge clk);
        chk({tag, ".c3_cs"}, bus.mem_chipselect, 0);
        chk({tag, ".c3_we"}, bus.mem_write, 0);
        chk({tag, ".c3_ready"}, bus.cpu_ready, 1);
    endtask

    initial begin
        reset         = 1'b1;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
`ifdef MEM_BRIDGE_BYTE_ENABLE_EN
        bus.cpu_be    = 2'b11;
`endif
        for (int i = 0; i < 1024; i++) begin
            mem[i]    = 8'(i) ^ 8'h5A;
            shadow[i] = 8'(i) ^ 8'h5A;
        end
        mem[10'h010] = 8'hAB; shadow[10'h010] = 8'hAB;
        mem[10'h011] = 8'hCD; shadow[10'h011] = 8'hCD;
        mem[10'h001] = 8'hC3; shadow[10'h001] = 8'hC3;

        // Reset values.
        @(negedge clk);
        @(negedge clk);
        chk("rst.ready", bus.cpu_ready, 1);
        chk("rst.rvalid", bus.cpu_rvalid, 0);
        chk("rst.rdata", bus.cpu_rdata, 0);
        chk("rst.addr", bus.mem_address, 0);
        chk("rst.cs", bus.mem_chipselect, 0);
        chk("rst.we", bus.mem_write, 0);
        chk("rst.wd", bus.mem_writedata, 0);
        chk("rst.clken", bus.mem_clken, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("run.clken", bus.mem_clken, 1);
        chk("idle.cs", bus.mem_chipselect, 0);

        // Big-endian read of preloaded bytes 0x010/0x011.
        do_read(9'h008, 16'hABCD, "rd008");
        @(negedge clk);
        chk("rd008.pulse_end", bus.cpu_rvalid, 0);
        chk("rd008.hold", bus.cpu_rdata, 16'hABCD);

        // Top word of memory.
        do_write(9'h1FF, 16'h1234, "wr1ff");
        shadow[10'h3FE] = 8'h12;
        shadow[10'h3FF] = 8'h34;
        mem_compare("wr1ff.mem");

        // Read back, then issue the next read in the rvalid cycle.
        do_read(9'h1FF, 16'h1234, "rd1ff");
        do_read(9'h000, 16'h5AC3, "rd000_b2b");
        @(negedge clk);
        chk("rd000.pulse_end", bus.cpu_rvalid, 0);

        // Reset in the middle of a read (during RD_LO).
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 9'h008;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        @(negedge clk);
        chk("rstmid.c2_addr", bus.mem_address, 10'h011);
        chk("rstmid.c2_cs", bus.mem_chipselect, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid.cs", bus.mem_chipselect, 0);
        chk("rstmid.ready", bus.cpu_ready, 1);
        chk("rstmid.rvalid", bus.cpu_rvalid, 0);
        chk("rstmid.rdata", bus.cpu_rdata, 0);
        chk("rstmid.clken", bus.mem_clken, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid.after_rvalid", bus.cpu_rvalid, 0);
        chk("rstmid.after_cs", bus.mem_chipselect, 0);
        chk("rstmid.after_rdata", bus.cpu_rdata, 0);
        chk("rstmid.after_clken", bus.mem_clken, 1);

`ifdef MEM_BRIDGE_BYTE_ENABLE_EN
        // Low byte only.
        chk("be01.ready", bus.cpu_ready, 1);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 9'h004;
        bus.cpu_wdata = 16'hBEEF;
        bus.cpu_be    = 2'b01;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        chk("be01.c1_addr", bus.mem_address, 10'h009);
        chk("be01.c1_we", bus.mem_write, 1);
        chk("be01.c1_wd", bus.mem_writedata, 8'hEF);
        chk("be01.c1_ready", bus.cpu_ready, 0);
        @(negedge clk);
        chk("be01.c2_ready", bus.cpu_ready, 1);
        chk("be01.c2_cs", bus.mem_chipselect, 0);
        shadow[10'h009] = 8'hEF;
        mem_compare("be01.mem");

        // No byte enabled.
        bus.cpu_req   = 1'b1;
        bus.cpu_addr  = 9'h005;
        bus.cpu_wdata = 16'hFFFF;
        bus.cpu_be    = 2'b00;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        chk("be00.ready", bus.cpu_ready, 1);
        chk("be00.cs", bus.mem_chipselect, 0);
        chk("be00.we", bus.mem_write, 0);
        @(negedge clk);
        chk("be00.cs2", bus.mem_chipselect, 0);
        mem_compare("be00.mem");
        bus.cpu_be = 2'b11;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
